settings_bank_marine_radar: RTL
===============================

// Module: settings_bank_marine_radar
// PURPOSE
//  Parametrised bank of N_REGS serial-bus setting registers at consecutive addresses from BASE_ADDR.
//  Each register is either immediate or sweep-deferred. Deferred writes land in a shadow copy and
//  reach the live outputs only on a commit event, so radar parameters never change mid-sweep.
//  Adds a control register (soft reset, forced commit), per-register change strobes and registered
//  readback. Sits between the serial settings bus and the marine radar DSP / trigger / ARP / ACP logic.
// PARAMETERS
//  N_REGS       16       number of setting registers (1..32)
//  REG_WIDTH    32       width of every register; serial_data[REG_WIDTH-1:0] is stored
//  BASE_ADDR    7'd32    serial address of register 0; register i at BASE_ADDR+i
//  CTRL_ADDR    7'd31    serial address of control register; must lie outside the bank range
//  DEFER_MASK   {N_REGS{1'b0}}   bit i = 1: register i is sweep-deferred
//  RESET_VALS   {N_REGS*REG_WIDTH{1'b0}}  flattened reset values, register i at [i*REG_WIDTH +: REG_WIDTH]
//  SRST_CYCLES  16       soft_reset pulse length in master_clk cycles (>=1)
// PORTS
//  master_clk     in   1                system clock; all logic on rising edge
//  reset_n        in   1                asynchronous, active-low reset
//  serial_addr    in   7                settings bus address
//  serial_data    in   32               settings bus data
//  serial_strobe  in   1                one-cycle write strobe
//  commit_req     in   1                sweep-boundary pulse (e.g. trigger or ARP); commits pending shadows
//  rd_addr        in   5                readback register index
//  live_out       out  N_REGS*REG_WIDTH live register values, flattened
//  changed        out  N_REGS           one-cycle pulse the cycle after live register i is updated
//  pending        out  N_REGS           shadow of register i differs from live, awaiting commit
//  soft_reset     out  1                active-high reset for downstream DSP
//  rd_data        out  REG_WIDTH        live value of register rd_addr, one cycle after rd_addr
// BEHAVIOUR
//  Reset (reset_n low, async): live = shadow = RESET_VALS; changed, pending = 0; soft_reset = 1;
//   soft-reset counter loads SRST_CYCLES; rd_data = 0.
//  Decode: hit_i = serial_strobe & (serial_addr == BASE_ADDR+i).
//   Addresses outside the bank and not CTRL_ADDR are ignored.
//  Immediate register (DEFER_MASK[i] = 0): on hit_i, live_i and shadow_i <= data at the same edge;
//   changed[i] = 1 for the following cycle. The strobe fires even when the value is unchanged.
//  Deferred register, on hit_i: shadow_i <= data; pending[i] <= 1; live_i untouched.
//  Commit event = commit_req | (CTRL write with bit1 = 1).
//   On commit, for every i with pending[i] = 1: live_i <= shadow_i (pre-edge value),
//   changed[i] pulses, pending[i] <= 0.
//  Write and commit in the same cycle on register i: live_i takes the OLD shadow; shadow_i takes
//   the new data; pending[i] stays 1. The new value waits for the next commit.
//   If pending[i] was 0, live_i is unchanged and pending[i] <= 1.
//  Back-to-back commits with nothing pending produce no changed pulses.
//  CTRL write, bit0 = 1: soft reset. In the next cycle every live and shadow register <= RESET_VALS,
//   pending <= 0, every changed bit pulses once, soft_reset asserts, and the counter reloads
//   SRST_CYCLES. soft_reset stays high exactly SRST_CYCLES cycles, then deasserts.
//   A new bit0 write during the pulse restarts the count.
//  CTRL bit0 and bit1 together: soft reset wins; the commit is discarded.
//  Bank writes during soft_reset are accepted normally. The bank never resets from its own
//   soft_reset output.
//  After reset_n deasserts: soft_reset holds high for SRST_CYCLES cycles, then deasserts.
//  Readback: rd_data <= live[rd_addr] each cycle; rd_addr >= N_REGS returns 0; latency 1 cycle.
//  CTRL reads are not supported.
// STRUCTURE
//  Shared package / include: register-address constants (FR_* style), CTRL bit positions
//   (CTRL_SRST = 0, CTRL_COMMIT = 1), default RESET_VALS and DEFER_MASK for the radar build.
//  One sub-module, setting_slot: one register holding live, shadow and pending. Its inputs are
//   hit, data, commit, srst and the reset value; its outputs are live, changed and pending.
//   Generate N_REGS instances of it. The top level holds decode, CTRL, the soft-reset counter
//   and the readback mux.
// TESTING
//  1. Reset: reset_n low then high. live == RESET_VALS, pending = 0; soft_reset is high for
//     16 cycles after release, then low.
//  2. Immediate write: reg 0 immediate, write 0x1234 at BASE_ADDR. live0 = 0x1234 next cycle;
//     changed[0] is a one-cycle pulse; rd_addr = 0 returns 0x1234 one cycle later.
//  3. Deferred write: reg 3 deferred, write 0xABCD. live3 holds its old value and pending[3] = 1.
//     On commit_req: live3 = 0xABCD, changed[3] pulses, pending[3] = 0.
//  4. Collision: reg 3 pending with 0x0005; write 0x0007 in the same cycle as commit_req.
//     live3 = 0x0005, pending[3] stays 1; the next commit sets live3 = 0x0007.
//  5. Soft reset: write CTRL = 0x3 while regs are pending. All live = RESET_VALS, pending = 0,
//     no commit of the old shadows, soft_reset high for 16 cycles.
//  6. Address guard: writes to BASE_ADDR+N_REGS and BASE_ADDR-2. No live change, no changed
//     pulse; rd_addr = N_REGS returns 0.

Source files
------------

// File: rtl/settings_bank_marine_radar_pkg.sv
// Shared constants for the marine radar settings bank: serial addresses,
// control-register bit positions and the radar build's reset/defer tables.
package settings_bank_marine_radar_pkg;

  // Serial addresses of the radar setting registers (bank base at 32)
  localparam logic [6:0] FR_CTRL      = 7'd31;
  localparam logic [6:0] FR_BASE      = 7'd32;
  localparam logic [6:0] FR_TX_PRF    = 7'd32;
  localparam logic [6:0] FR_PULSE_LEN = 7'd33;
  localparam logic [6:0] FR_GAIN      = 7'd34;
  localparam logic [6:0] FR_STC_CURVE = 7'd35;
  localparam logic [6:0] FR_FTC_LEVEL = 7'd36;
  localparam logic [6:0] FR_RANGE_SEL = 7'd37;
  localparam logic [6:0] FR_ARP_CFG   = 7'd38;
  localparam logic [6:0] FR_ACP_SCALE = 7'd39;
  localparam logic [6:0] FR_TRIG_DLY  = 7'd40;

  // Control register bit positions
  localparam int unsigned CTRL_SRST   = 0;
  localparam int unsigned CTRL_COMMIT = 1;

  // Radar build: 16 x 32-bit registers; gain/STC/FTC/range and trigger delay
  // only change on a sweep boundary.
  localparam int unsigned RADAR_N_REGS = 16;
  localparam logic [RADAR_N_REGS-1:0] RADAR_DEFER_MASK = 16'h013C;
  localparam logic [RADAR_N_REGS*32-1:0] RADAR_RESET_VALS = {
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0040,
    32'h0000_0800, 32'h0000_0001, 32'h0000_0003, 32'h0000_0010,
    32'h0000_0000, 32'h0000_0080, 32'h0000_0064, 32'h0000_03E8
  };

endpackage

// File: rtl/settings_bank_marine_radar_setting_slot.sv
// One setting register: live value, shadow copy and pending flag.
// Immediate slots update live on a hit; deferred slots stage into the
// shadow and publish it on the next commit.
module setting_slot
  import settings_bank_marine_radar_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter bit          DEFERRED = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             hit_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             commit_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] rst_val_i,
  output logic [WIDTH-1:0] live_o,
  output logic             changed_o,
  output logic             pending_o
);

  logic [WIDTH-1:0] live_q, live_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             changed_q, changed_d;

  // Next state: soft reset first, then commit of the old shadow, then the
  // write, so a same-cycle write lands in the shadow and stays pending.
  always_comb begin
    live_d    = live_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    changed_d = 1'b0;
    if (srst_i) begin
      live_d    = rst_val_i;
      shadow_d  = rst_val_i;
      pending_d = 1'b0;
      changed_d = 1'b1;
    end else begin
      if (commit_i && pending_q) begin
        live_d    = shadow_q;
        pending_d = 1'b0;
        changed_d = 1'b1;
      end
      if (hit_i) begin
        shadow_d = data_i;
        if (DEFERRED) begin
          pending_d = 1'b1;
        end else begin
          live_d    = data_i;
          changed_d = 1'b1;
        end
      end
    end
  end

  // State registers, loaded with the slot's reset value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      live_q    <= rst_val_i;
      shadow_q  <= rst_val_i;
      pending_q <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      live_q    <= live_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      changed_q <= changed_d;
    end
  end

  assign live_o    = live_q;
  assign changed_o = changed_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/settings_bank_marine_radar.sv
// Settings bank between the serial settings bus and the radar DSP/trigger/
// ARP/ACP logic: address decode, control register, soft-reset pulse
// generator and registered readback around N_REGS setting slots.
module settings_bank_marine_radar
  import settings_bank_marine_radar_pkg::*;
#(
  parameter int unsigned               N_REGS      = 16,
  parameter int unsigned               REG_WIDTH   = 32,
  parameter logic [6:0]                BASE_ADDR   = FR_BASE,
  parameter logic [6:0]                CTRL_ADDR   = FR_CTRL,
  parameter logic [N_REGS-1:0]         DEFER_MASK  = '0,
  parameter logic [N_REGS*REG_WIDTH-1:0] RESET_VALS = '0,
  parameter int unsigned               SRST_CYCLES = 16
) (
  input  logic                          master_clk,
  input  logic                          reset_n,
  input  logic [6:0]                    serial_addr,
  input  logic [31:0]                   serial_data,
  input  logic                          serial_strobe,
  input  logic                          commit_req,
  input  logic [4:0]                    rd_addr,
  output logic [N_REGS*REG_WIDTH-1:0]   live_out,
  output logic [N_REGS-1:0]             changed,
  output logic [N_REGS-1:0]             pending,
  output logic                          soft_reset,
  output logic [REG_WIDTH-1:0]          rd_data
);

  localparam int unsigned CW = $clog2(SRST_CYCLES + 1);

  logic [REG_WIDTH-1:0] live_w [N_REGS];
  logic                 ctrl_wr;
  logic                 srst;
  logic                 commit;
  logic [CW-1:0]        srst_cnt_q, srst_cnt_d;
  logic [REG_WIDTH-1:0] rd_data_q, rd_data_d;

  assign ctrl_wr = serial_strobe && (serial_addr == CTRL_ADDR);
  assign srst    = ctrl_wr && serial_data[CTRL_SRST];
  assign commit  = commit_req || (ctrl_wr && serial_data[CTRL_COMMIT]);

  for (genvar g = 0; g < int'(N_REGS); g++) begin : g_slot
    logic hit;
    assign hit = serial_strobe && (32'(serial_addr) == 32'(BASE_ADDR) + 32'(g));

    setting_slot #(
      .WIDTH    (REG_WIDTH),
      .DEFERRED (DEFER_MASK[g])
    ) u_slot (
      .clk_i     (master_clk),
      .rst_ni    (reset_n),
      .hit_i     (hit),
      .data_i    (serial_data[REG_WIDTH-1:0]),
      .commit_i  (commit),
      .srst_i    (srst),
      .rst_val_i (RESET_VALS[g*REG_WIDTH +: REG_WIDTH]),
      .live_o    (live_w[g]),
      .changed_o (changed[g]),
      .pending_o (pending[g])
    );

    assign live_out[g*REG_WIDTH +: REG_WIDTH] = live_w[g];
  end

  // Soft-reset counter: reload on a CTRL soft reset, count down to zero
  always_comb begin
    srst_cnt_d = srst_cnt_q;
    if (srst) begin
      srst_cnt_d = CW'(SRST_CYCLES);
    end else if (srst_cnt_q != '0) begin
      srst_cnt_d = srst_cnt_q - CW'(1);
    end
  end

  // Readback mux; indices past the bank read as zero
  always_comb begin
    rd_data_d = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (32'(rd_addr) == i) begin
        rd_data_d = live_w[i];
      end
    end
  end

  // Counter and readback registers
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      srst_cnt_q <= CW'(SRST_CYCLES);
      rd_data_q  <= '0;
    end else begin
      srst_cnt_q <= srst_cnt_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign soft_reset = (srst_cnt_q != '0);
  assign rd_data    = rd_data_q;

endmodule
